// File: rtl/bullet_pool.sv
// ============================================================================
// bullet_pool : fixed pool of projectile slots with spawn, flight, hit and
//               per-pixel circular rendering.          Revision 1.0
// ============================================================================
`default_nettype none

module bullet_pool #(
    parameter int NUM_BULLETS = 4,
    parameter int STEP        = 3,
    parameter int SIZE        = 3,
    parameter int X_MAX       = 639,
    parameter int Y_MAX       = 479,
    parameter int COOLDOWN    = 8,
    parameter int HIT_FRAMES  = 4
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   frame_tick,
    input  logic                   fire,
    input  logic [3:0]             aim,
    input  logic                   facing,
    input  logic [9:0]             player_x,
    input  logic [9:0]             player_y,
    input  logic [9:0]             player_w,
    input  logic [9:0]             player_h,
    input  logic [9:0]             draw_x,
    input  logic [9:0]             draw_y,
    input  logic [NUM_BULLETS-1:0] hit,
    output logic [NUM_BULLETS-1:0] active,
    output logic                   bullet_on,
    output logic [((NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1)-1:0] bullet_id,
    output logic                   fire_ack,
    output logic                   fire_drop
);

    localparam int IDW = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;
    localparam int HW  = (HIT_FRAMES > 1) ? $clog2(HIT_FRAMES) : 1;
    localparam int CW  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    localparam logic [9:0]    STEP_POS = 10'(STEP);
    localparam logic [9:0]    STEP_NEG = 10'(-STEP);
    localparam logic [9:0]    XLIM     = 10'(X_MAX);
    localparam logic [9:0]    YLIM     = 10'(Y_MAX);
    localparam logic [HW-1:0] HIT_INIT = HW'(HIT_FRAMES - 1);
    localparam logic [CW-1:0] CD_INIT  = CW'(COOLDOWN);
    localparam logic [21:0]   R2_FLY   = 22'(SIZE * SIZE);
    localparam logic [21:0]   R2_HIT   = 22'((SIZE + 2) * (SIZE + 2));

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FLY  = 2'd1,
        S_HIT  = 2'd2
    } slot_t;

    slot_t         st    [NUM_BULLETS];
    slot_t         st_n  [NUM_BULLETS];
    logic [9:0]    px    [NUM_BULLETS];
    logic [9:0]    px_n  [NUM_BULLETS];
    logic [9:0]    py    [NUM_BULLETS];
    logic [9:0]    py_n  [NUM_BULLETS];
    logic [9:0]    vx    [NUM_BULLETS];
    logic [9:0]    vx_n  [NUM_BULLETS];
    logic [9:0]    vy    [NUM_BULLETS];
    logic [9:0]    vy_n  [NUM_BULLETS];
    logic [HW-1:0] hc    [NUM_BULLETS];
    logic [HW-1:0] hc_n  [NUM_BULLETS];
    logic [NUM_BULLETS-1:0] active_n;

    logic          fire_q;
    logic          fire_edge;
    logic          pending;
    logic [CW-1:0] cd;
    logic [CW-1:0] cd_n;
    logic          found;
    logic          spawn;
    int            sel;
    logic [9:0]    spawn_x;
    logic [9:0]    spawn_y;
    logic [9:0]    spawn_vx;
    logic [9:0]    spawn_vy;

    // Spawn arbitration looks only at slots idle before this tick, so a slot
    // freed on the same tick cannot be reused until the next one.
    always_comb begin
        fire_edge = fire & ~fire_q;
        found     = 1'b0;
        sel       = 0;
        for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
            if (st[i] == S_IDLE) begin
                found = 1'b1;
                sel   = i;
            end
        end
        spawn     = frame_tick & pending & (cd == '0) & found;
        fire_ack  = spawn;
        fire_drop = frame_tick & pending & ~spawn;
        if (spawn)
            cd_n = CD_INIT;
        else if (frame_tick && (cd != '0))
            cd_n = cd - 1'b1;
        else
            cd_n = cd;
    end

    always_comb begin
        spawn_x  = player_x + (player_w >> 1);
        spawn_y  = player_y + (player_h >> 1);
        spawn_vx = facing ? STEP_NEG : STEP_POS;
        spawn_vy = 10'd0;
        case (aim)
            4'd1: begin spawn_vx = 10'd0;    spawn_vy = STEP_NEG; end
            4'd2: begin spawn_vx = STEP_NEG; spawn_vy = 10'd0;    end
            4'd4: begin spawn_vx = STEP_POS; spawn_vy = 10'd0;    end
            4'd5: begin spawn_vx = STEP_NEG; spawn_vy = STEP_NEG; end
            4'd6: begin spawn_vx = STEP_POS; spawn_vy = STEP_NEG; end
            4'd7: begin spawn_vx = STEP_NEG; spawn_vy = STEP_POS; end
            4'd8: begin spawn_vx = STEP_POS; spawn_vy = STEP_POS; end
            default: ;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_BULLETS; i++) begin
            st_n[i] = st[i];
            px_n[i] = px[i];
            py_n[i] = py[i];
            vx_n[i] = vx[i];
            vy_n[i] = vy[i];
            hc_n[i] = hc[i];
            if (frame_tick) begin
                case (st[i])
                    S_IDLE: begin
                        if (spawn && (sel == i)) begin
                            st_n[i] = S_FLY;
                            px_n[i] = spawn_x;
                            py_n[i] = spawn_y;
                            vx_n[i] = spawn_vx;
                            vy_n[i] = spawn_vy;
                        end
                    end
                    S_FLY: begin
                        // Unsigned compare also retires bullets that wrapped below 0.
                        if ((px[i] > XLIM) || (py[i] > YLIM)) begin
                            st_n[i] = S_IDLE;
                        end else if (hit[i]) begin
                            st_n[i] = S_HIT;
                            hc_n[i] = HIT_INIT;
                        end else begin
                            px_n[i] = px[i] + vx[i];
                            py_n[i] = py[i] + vy[i];
                        end
                    end
                    S_HIT: begin
                        if (hc[i] == '0)
                            st_n[i] = S_IDLE;
                        else
                            hc_n[i] = hc[i] - 1'b1;
                    end
                    default: st_n[i] = S_IDLE;
                endcase
            end
            active_n[i] = (st_n[i] != S_IDLE);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fire_q  <= 1'b0;
            pending <= 1'b0;
            cd      <= '0;
            active  <= '0;
            for (int i = 0; i < NUM_BULLETS; i++) begin
                st[i] <= S_IDLE;
                px[i] <= '0;
                py[i] <= '0;
                vx[i] <= '0;
                vy[i] <= '0;
                hc[i] <= '0;
            end
        end else begin
            fire_q  <= fire;
            pending <= frame_tick ? fire_edge : (pending | fire_edge);
            cd      <= cd_n;
            active  <= active_n;
            for (int i = 0; i < NUM_BULLETS; i++) begin
                st[i] <= st_n[i];
                px[i] <= px_n[i];
                py[i] <= py_n[i];
                vx[i] <= vx_n[i];
                vy[i] <= vy_n[i];
                hc[i] <= hc_n[i];
            end
        end
    end

    // Squared distance is taken modulo 2^22 on sign-extended deltas; the true
    // value is below 2^21 so the unsigned result is exact.
    always_comb begin
        logic [10:0] dx;
        logic [10:0] dy;
        logic [21:0] dxe;
        logic [21:0] dye;
        logic [21:0] dsq;
        logic [21:0] lim;
        dx        = '0;
        dy        = '0;
        dxe       = '0;
        dye       = '0;
        dsq       = '0;
        lim       = '0;
        bullet_on = 1'b0;
        bullet_id = '0;
        for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
            dx  = {1'b0, draw_x} - {1'b0, px[i]};
            dy  = {1'b0, draw_y} - {1'b0, py[i]};
            dxe = {{11{dx[10]}}, dx};
            dye = {{11{dy[10]}}, dy};
            dsq = dxe * dxe + dye * dye;
            lim = (st[i] == S_HIT) ? R2_HIT : R2_FLY;
            if ((st[i] != S_IDLE) && (dsq <= lim)) begin
                bullet_on = 1'b1;
                bullet_id = IDW'(i);
            end
        end
    end

endmodule

`default_nettype wire
